// File: rtl/sensor_bus_arbiter_pkg.sv
// Shared definitions for the sensor bus arbiter: FSM encoding, channel
// indices and the default BUSY timeout.
package sensor_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic CH_HR   = 1'b0;   // heart-rate channel
    localparam logic CH_TEMP = 1'b1;   // temperature channel

    localparam int TIMEOUT_DEFAULT = 15;

    // One-hot grant/ack pattern for a channel index.
    function automatic logic [1:0] ch_onehot(input logic ch);
        return (ch == CH_TEMP) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sensor_bus_arbiter_if.sv
// Sensor request/data inputs and the arbitrated bus handshake, bundled so
// the arbiter and its environment share one definition.
interface sensor_bus_arbiter_if;

    logic       req0;
    logic       req1;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [1:0] ack;
    logic [1:0] grant;
    logic [7:0] bus_data;
    logic       bus_valid;
    logic       bus_ready;
    logic       timeout_err;
    logic [7:0] drop_cnt;

    // Arbiter side.
    modport master (
        input  req0, req1, data0, data1, bus_ready,
        output ack, grant, bus_data, bus_valid, timeout_err, drop_cnt
    );

    // Sensor channels and bus consumer side.
    modport slave (
        output req0, req1, data0, data1, bus_ready,
        input  ack, grant, bus_data, bus_valid, timeout_err, drop_cnt
    );

endinterface

// File: rtl/sensor_bus_arbiter_byte_mux2.sv
// Two-way byte selector feeding the arbiter's bus_data capture register.
module byte_mux2 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_sel,
    output logic [7:0] o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/sensor_bus_arbiter.sv
// Round-robin arbiter granting one of two sensor channels onto a
// valid/ready byte bus, with BUSY timeout, owner-abort detection and a
// saturating count of aborted grants.
module sensor_bus_arbiter
    import sensor_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sensor_bus_arbiter_if.master  bus
);

    // Timer value on the last allowed BUSY cycle.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic       r_last;
    logic [1:0] r_grant;
    logic [7:0] r_bus_data;
    logic [1:0] r_ack;
    logic       r_timeout_err;
    logic [7:0] r_drop_cnt;
    logic [7:0] r_timer;

    state_t     w_state_next;
    logic       w_last_next;
    logic [1:0] w_grant_next;
    logic [7:0] w_bus_data_next;
    logic [1:0] w_ack_next;
    logic       w_timeout_err_next;
    logic [7:0] w_drop_cnt_next;
    logic [7:0] w_timer_next;

    logic [1:0] w_req;
    logic       w_winner;
    logic       w_owner;
    logic       w_owner_req;
    logic [7:0] w_drop_sat;
    logic [7:0] w_mux_byte;
    logic       w_exit;

    assign w_req       = {bus.req1, bus.req0};
    // A lone request wins outright; on contention the channel not granted
    // last time takes the bus.
    assign w_winner    = (&w_req) ? ~r_last : w_req[CH_TEMP];
    assign w_owner     = r_grant[CH_TEMP] ? CH_TEMP : CH_HR;
    assign w_owner_req = w_req[w_owner];
    assign w_drop_sat  = (r_drop_cnt == 8'hFF) ? r_drop_cnt : r_drop_cnt + 8'd1;

    byte_mux2 u_byte_mux (
        .i_a   (bus.data0),
        .i_b   (bus.data1),
        .i_sel (w_winner),
        .o_y   (w_mux_byte)
    );

    // State and datapath registers; reset leaves channel 0 with priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_last        <= CH_TEMP;
            r_grant       <= 2'b00;
            r_bus_data    <= 8'h00;
            r_ack         <= 2'b00;
            r_timeout_err <= 1'b0;
            r_drop_cnt    <= 8'h00;
            r_timer       <= 8'h00;
        end else begin
            r_state       <= w_state_next;
            r_last        <= w_last_next;
            r_grant       <= w_grant_next;
            r_bus_data    <= w_bus_data_next;
            r_ack         <= w_ack_next;
            r_timeout_err <= w_timeout_err_next;
            r_drop_cnt    <= w_drop_cnt_next;
            r_timer       <= w_timer_next;
        end
    end

    // Next-state logic: arbitrate in IDLE, resolve handshake / timeout /
    // owner abort in BUSY (handshake first), then one idle GAP cycle.
    always_comb begin
        w_state_next       = r_state;
        w_last_next        = r_last;
        w_grant_next       = r_grant;
        w_bus_data_next    = r_bus_data;
        w_ack_next         = 2'b00;
        w_timeout_err_next = 1'b0;
        w_drop_cnt_next    = r_drop_cnt;
        w_timer_next       = r_timer;
        w_exit             = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_grant_next    = ch_onehot(w_winner);
                    w_bus_data_next = w_mux_byte;
                    w_timer_next    = 8'h00;
                    w_state_next    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.bus_ready) begin
                    w_ack_next = ch_onehot(w_owner);
                    w_exit     = 1'b1;
                end else if (r_timer == TIMER_LAST) begin
                    w_timeout_err_next = 1'b1;
                    w_drop_cnt_next    = w_drop_sat;
                    w_exit             = 1'b1;
                end else if (!w_owner_req) begin
                    w_drop_cnt_next = w_drop_sat;
                    w_exit          = 1'b1;
                end else begin
                    w_timer_next = r_timer + 8'd1;
                end
                if (w_exit) begin
                    w_state_next    = ST_GAP;
                    w_grant_next    = 2'b00;
                    w_bus_data_next = 8'h00;
                    w_timer_next    = 8'h00;
                    w_last_next     = w_owner;
                end
            end
            ST_GAP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.grant       = r_grant;
    assign bus.bus_data    = r_bus_data;
    assign bus.bus_valid   = (r_state == ST_BUSY);
    assign bus.ack         = r_ack;
    assign bus.timeout_err = r_timeout_err;
    assign bus.drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_sensor_bus_arbiter.sv
// Self-checking bench for sensor_bus_arbiter: directed scenarios plus
// randomized transactions scored against a transaction-level model.
module tb_sensor_bus_arbiter;

    localparam int TO = 15;

    logic clk;
    logic rst_n;
    int   checks    = 0;
    int   errors    = 0;
    int   exp_last  = 1;   // channel granted most recently (model)
    int   exp_drops = 0;   // aborted grants, saturating at 255 (model)

    sensor_bus_arbiter_if bus ();

    sensor_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.data0 = 8'h5A; bus.data1 = 8'hA5; bus.bus_ready = 1'b1;
        tick(); tick();
        checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", bus.grant); end
        checks++; if (bus.ack !== 2'b00) begin errors++; $display("FAIL reset_ack got=%b exp=00", bus.ack); end
        checks++; if (bus.bus_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.bus_valid); end
        checks++; if (bus.bus_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", bus.bus_data); end
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr got=%b exp=0", bus.timeout_err); end
        checks++; if (bus.drop_cnt !== 8'h00) begin errors++; $display("FAIL reset_drop got=%h exp=00", bus.drop_cnt); end
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.bus_ready = 1'b0;
        rst_n = 1'b1;
        exp_last = 1; exp_drops = 0;
        $display("reset released");
    endtask

    task automatic test_single();
        bus.req0 = 1'b1; bus.data0 = 8'h48; bus.bus_ready = 1'b1;
        tick();
        checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL single_grant got=%b exp=01", bus.grant); end
        checks++; if (bus.bus_data !== 8'h48) begin errors++; $display("FAIL single_data got=%h exp=48", bus.bus_data); end
        checks++; if (bus.bus_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", bus.bus_valid); end
        tick();
        checks++; if (bus.ack !== 2'b01) begin errors++; $display("FAIL single_ack got=%b exp=01", bus.ack); end
        checks++; if (bus.grant !== 2'b00 || bus.bus_valid !== 1'b0) begin errors++; $display("FAIL single_gap got=%b/%b exp=00/0", bus.grant, bus.bus_valid); end
        checks++; if (bus.bus_data !== 8'h00) begin errors++; $display("FAIL single_gap_data got=%h exp=00", bus.bus_data); end
        bus.req0 = 1'b0; bus.bus_ready = 1'b0;
        tick();
        checks++; if (bus.ack !== 2'b00 || bus.grant !== 2'b00) begin errors++; $display("FAIL single_idle got=%b/%b exp=00/00", bus.ack, bus.grant); end
        exp_last = 0;
        $display("single ch0 transfer 48 done");
    endtask

    task automatic test_round_robin();
        int w = 0;
        logic [1:0] exp_g, exp_a;
        logic [7:0] exp_d;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.data0 = 8'hA1; bus.data1 = 8'h5C; bus.bus_ready = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k % 3 == 1) begin
                w = (exp_last == 0) ? 1 : 0;
                exp_g = (w == 1) ? 2'b10 : 2'b01; exp_a = 2'b00; exp_d = (w == 1) ? 8'h5C : 8'hA1;
            end else if (k % 3 == 2) begin
                exp_g = 2'b00; exp_a = (w == 1) ? 2'b10 : 2'b01; exp_d = 8'h00;
                exp_last = w;
            end else begin
                exp_g = 2'b00; exp_a = 2'b00; exp_d = 8'h00;
            end
            checks++; if (bus.grant !== exp_g) begin errors++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", k, bus.grant, exp_g); end
            checks++; if (bus.ack !== exp_a) begin errors++; $display("FAIL rr_ack cyc=%0d got=%b exp=%b", k, bus.ack, exp_a); end
            checks++; if (bus.bus_data !== exp_d) begin errors++; $display("FAIL rr_data cyc=%0d got=%h exp=%h", k, bus.bus_data, exp_d); end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.bus_ready = 1'b0;
        $display("round robin 4 grants done");
    endtask

    task automatic test_timeout();
        bus.req1 = 1'b1; bus.data1 = 8'h3E; bus.bus_ready = 1'b0;
        tick();
        checks++; if (bus.grant !== 2'b10) begin errors++; $display("FAIL to_grant got=%b exp=10", bus.grant); end
        for (int c = 1; c < TO; c++) begin
            tick();
            checks++; if (bus.grant !== 2'b10 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL to_early cyc=%0d got=%b/%b exp=10/0", c, bus.grant, bus.timeout_err); end
        end
        tick();
        exp_drops++;
        exp_last = 1;
        checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_err got=%b exp=1", bus.timeout_err); end
        checks++; if (bus.ack !== 2'b00) begin errors++; $display("FAIL to_ack got=%b exp=00", bus.ack); end
        checks++; if (bus.drop_cnt !== exp_drops[7:0]) begin errors++; $display("FAIL to_drop got=%0d exp=%0d", bus.drop_cnt, exp_drops); end
        bus.req1 = 1'b0;
        tick();
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL to_pulse got=%b exp=0", bus.timeout_err); end
        $display("timeout on ch1 after %0d cycles", TO);
    endtask

    task automatic test_races();
        // Handshake on the exact timeout cycle.
        bus.req0 = 1'b1; bus.data0 = 8'h77; bus.bus_ready = 1'b0;
        tick();
        checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL race_to_grant got=%b exp=01", bus.grant); end
        repeat (TO - 1) tick();
        bus.bus_ready = 1'b1;
        tick();
        checks++; if (bus.ack !== 2'b01) begin errors++; $display("FAIL race_to_ack got=%b exp=01", bus.ack); end
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL race_to_err got=%b exp=0", bus.timeout_err); end
        checks++; if (bus.drop_cnt !== exp_drops[7:0]) begin errors++; $display("FAIL race_to_drop got=%0d exp=%0d", bus.drop_cnt, exp_drops); end
        exp_last = 0;
        bus.req0 = 1'b0; bus.bus_ready = 1'b0;
        tick();
        $display("handshake vs timeout race done");
        // Handshake in the same cycle the owner drops its request.
        bus.req1 = 1'b1; bus.data1 = 8'h19;
        tick();
        checks++; if (bus.grant !== 2'b10) begin errors++; $display("FAIL race_drop_grant got=%b exp=10", bus.grant); end
        tick();
        bus.req1 = 1'b0; bus.bus_ready = 1'b1;
        tick();
        checks++; if (bus.ack !== 2'b10) begin errors++; $display("FAIL race_drop_ack got=%b exp=10", bus.ack); end
        checks++; if (bus.drop_cnt !== exp_drops[7:0]) begin errors++; $display("FAIL race_drop_cnt got=%0d exp=%0d", bus.drop_cnt, exp_drops); end
        exp_last = 1;
        bus.bus_ready = 1'b0;
        tick();
        $display("handshake vs request drop race done");
    endtask

    task automatic test_random();
        int r0, r1, w, mode, h, dd, n, exp_n;
        bit exp_ack, exp_to;
        logic [7:0] d0, d1, cap;
        logic [1:0] g;
        for (int t = 0; t < 40; t++) begin
            r0 = $urandom_range(0, 1); r1 = $urandom_range(0, 1);
            if (r0 == 0 && r1 == 0) r0 = 1;
            d0 = 8'($urandom); d1 = 8'($urandom);
            mode = $urandom_range(0, 1);
            h = $urandom_range(0, TO + 2);
            dd = $urandom_range(0, TO - 2);
            // Model: who wins, and how the grant ends.
            w = (r0 == 1 && r1 == 1) ? ((exp_last == 0) ? 1 : 0) : ((r1 == 1) ? 1 : 0);
            g = (w == 1) ? 2'b10 : 2'b01;
            cap = (w == 1) ? d1 : d0;
            if (mode == 0) begin
                exp_ack = (h < TO); exp_to = (h >= TO); exp_n = (h < TO) ? h + 1 : TO;
            end else begin
                exp_ack = 1'b0; exp_to = 1'b0; exp_n = dd + 1;
            end
            bus.req0 = r0[0]; bus.req1 = r1[0]; bus.data0 = d0; bus.data1 = d1; bus.bus_ready = 1'b0;
            tick();
            checks++; if (bus.grant !== g) begin errors++; $display("FAIL rnd_grant txn=%0d got=%b exp=%b", t, bus.grant, g); end
            checks++; if (bus.bus_data !== cap) begin errors++; $display("FAIL rnd_data txn=%0d got=%h exp=%h", t, bus.bus_data, cap); end
            checks++; if (bus.bus_valid !== 1'b1) begin errors++; $display("FAIL rnd_valid txn=%0d got=%b exp=1", t, bus.bus_valid); end
            n = TO + 5;
            for (int c = 0; c < TO + 5; c++) begin
                bus.data0 = 8'($urandom); bus.data1 = 8'($urandom);
                if (w == 1) bus.req0 = 1'($urandom_range(0, 1));
                else        bus.req1 = 1'($urandom_range(0, 1));
                if (mode == 0 && c == h) bus.bus_ready = 1'b1;
                if (mode == 1 && c == dd) begin
                    if (w == 1) bus.req1 = 1'b0; else bus.req0 = 1'b0;
                end
                tick();
                if (bus.grant === 2'b00) begin
                    n = c + 1;
                    break;
                end
                checks++; if (bus.grant !== g || bus.bus_data !== cap) begin errors++; $display("FAIL rnd_stable txn=%0d got=%b/%h exp=%b/%h", t, bus.grant, bus.bus_data, g, cap); end
                checks++; if (bus.ack !== 2'b00 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rnd_early txn=%0d got=%b/%b exp=00/0", t, bus.ack, bus.timeout_err); end
            end
            if (!exp_ack) exp_drops = (exp_drops < 255) ? exp_drops + 1 : 255;
            exp_last = w;
            checks++; if (n != exp_n) begin errors++; $display("FAIL rnd_busy_len txn=%0d got=%0d exp=%0d", t, n, exp_n); end
            checks++; if (bus.ack !== (exp_ack ? g : 2'b00)) begin errors++; $display("FAIL rnd_ack txn=%0d got=%b exp=%b", t, bus.ack, exp_ack ? g : 2'b00); end
            checks++; if (bus.timeout_err !== exp_to) begin errors++; $display("FAIL rnd_terr txn=%0d got=%b exp=%b", t, bus.timeout_err, exp_to); end
            checks++; if (bus.drop_cnt !== exp_drops[7:0]) begin errors++; $display("FAIL rnd_drop txn=%0d got=%0d exp=%0d", t, bus.drop_cnt, exp_drops); end
            $display("txn %0d req=%0d%0d owner=%0d mode=%0d busy=%0d ack=%b terr=%b drops=%0d",
                     t, r1, r0, w, mode, n, bus.ack, bus.timeout_err, bus.drop_cnt);
            bus.req0 = 1'b0; bus.req1 = 1'b0; bus.bus_ready = 1'b0;
            tick();
            checks++; if (bus.ack !== 2'b00 || bus.timeout_err !== 1'b0 || bus.grant !== 2'b00) begin errors++; $display("FAIL rnd_idle txn=%0d got=%b/%b/%b exp=00/0/00", t, bus.ack, bus.timeout_err, bus.grant); end
        end
    endtask

    task automatic test_saturate();
        bus.req1 = 1'b0; bus.bus_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bus.req0 = 1'b1; bus.data0 = 8'(i);
            tick();
            bus.req0 = 1'b0;
            tick();
            exp_drops = (exp_drops < 255) ? exp_drops + 1 : 255;
            checks++; if (bus.drop_cnt !== exp_drops[7:0]) begin errors++; $display("FAIL sat_drop abort=%0d got=%0d exp=%0d", i, bus.drop_cnt, exp_drops); end
            checks++; if (bus.ack !== 2'b00 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL sat_flags abort=%0d got=%b/%b exp=00/0", i, bus.ack, bus.timeout_err); end
            tick();
        end
        exp_last = 0;
        $display("300 aborts done drop_cnt=%0d", bus.drop_cnt);
    endtask

    task automatic test_reset_mid_busy();
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.data0 = 8'h11; bus.data1 = 8'h22; bus.bus_ready = 1'b0;
        tick();
        checks++; if (bus.grant !== ((exp_last == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rst_pre_grant got=%b exp=%b", bus.grant, (exp_last == 0) ? 2'b10 : 2'b01); end
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.grant !== 2'b00 || bus.bus_valid !== 1'b0) begin errors++; $display("FAIL rst_async_grant got=%b/%b exp=00/0", bus.grant, bus.bus_valid); end
        checks++; if (bus.bus_data !== 8'h00 || bus.ack !== 2'b00) begin errors++; $display("FAIL rst_async_data got=%h/%b exp=00/00", bus.bus_data, bus.ack); end
        checks++; if (bus.timeout_err !== 1'b0 || bus.drop_cnt !== 8'h00) begin errors++; $display("FAIL rst_async_cnt got=%b/%0d exp=0/0", bus.timeout_err, bus.drop_cnt); end
        tick();
        rst_n = 1'b1;
        exp_last = 1; exp_drops = 0;
        tick();
        checks++; if (bus.grant !== 2'b01 || bus.bus_data !== 8'h11) begin errors++; $display("FAIL rst_after_grant got=%b/%h exp=01/11", bus.grant, bus.bus_data); end
        checks++; if (bus.ack !== 2'b00 || bus.drop_cnt !== 8'h00) begin errors++; $display("FAIL rst_after_flags got=%b/%0d exp=00/0", bus.ack, bus.drop_cnt); end
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.bus_ready = 1'b1;
        tick();
        checks++; if (bus.ack !== 2'b01) begin errors++; $display("FAIL rst_after_ack got=%b exp=01", bus.ack); end
        bus.bus_ready = 1'b0;
        tick();
        $display("reset mid-busy recovered to ch0");
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_races();
        test_random();
        test_saturate();
        test_reset_mid_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
